// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream input and image-RAM write port of the boot ROM loader.
//   slave  : the loader (consumes the stream, drives the RAM write port)
//   master : the stream source / RAM-side observer
interface rom_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_addr,
        output mem_data,
        output mem_we
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_addr,
        input  mem_data,
        input  mem_we
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: writes a framed boot image into the RAM behind the 6502 ROM window
// and holds the CPU in reset until a complete, in-range image has landed.
//
// Frame: SYNC_BYTE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes [, CHK]
// Address/length are big-endian; address bit 15 is ignored.
//
// Optional feature (define ROM_LOADER_CHECKSUM_EN): the frame carries a trailing
// XOR checksum of the payload; the CPU is released only if it matches.
module rom_loader #(
    parameter int         SIZE      = 8192,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         reset_n,
    rom_loader_if.slave  bus,
    output logic         cpu_reset_n,
    output logic         busy,
    output logic         done,
    output logic         error
);

    // FSM encoding
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] S_AHI = 4'd1;
    localparam logic [3:0] S_ALO = 4'd2;
    localparam logic [3:0] S_LHI = 4'd3;
    localparam logic [3:0] S_LLO = 4'd4;
    localparam logic [3:0] DATA  = 4'd5;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam logic [3:0] CHK   = 4'd6;
`endif
    localparam logic [3:0] DONE  = 4'd7;
    localparam logic [3:0] ERROR = 4'd8;

    // State entered once the last payload byte (or an empty payload) is taken.
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam logic [3:0] PAYLOAD_END = CHK;
`else
    localparam logic [3:0] PAYLOAD_END = DONE;
`endif

    // Upper bound of start + LEN, widened to the 17-bit compare domain.
    localparam logic [16:0] SIZE_17 = 17'(SIZE);

    logic [3:0]  state_q,   state_d;
    logic [6:0]  addr_hi_q, addr_hi_d;   // only bits [14:8] of the address matter
    logic [7:0]  len_hi_q,  len_hi_d;
    logic [14:0] addr_q,    addr_d;      // next payload write address
    logic [15:0] cnt_q,     cnt_d;       // payload bytes still expected
    logic        we_q,      we_d;
    logic [14:0] waddr_q,   waddr_d;
    logic [7:0]  wdata_q,   wdata_d;
    logic        rel_q,     rel_d;       // CPU reset release
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]  chk_q,     chk_d;       // running XOR of the payload
`endif

    logic        accept;
    logic        is_sync;
    logic [15:0] len_full;
    logic [16:0] span;

    assign bus.rx_ready = (state_q != DONE);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign is_sync      = (bus.rx_data == SYNC_BYTE);
    assign len_full     = {len_hi_q, bus.rx_data};
    assign span         = {2'b00, addr_q} + {1'b0, len_full};

    // Next-state and datapath decode for one accepted stream byte.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        len_hi_d  = len_hi_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
`ifdef ROM_LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif

        if (accept) begin
            case (state_q)
                IDLE, ERROR: begin
                    // Non-sync bytes are dropped; a sync byte opens a new frame.
                    if (is_sync) begin
                        state_d = S_AHI;
`ifdef ROM_LOADER_CHECKSUM_EN
                        chk_d   = 8'h00;
`endif
                    end
                end
                S_AHI: begin
                    addr_hi_d = bus.rx_data[6:0];
                    state_d   = S_ALO;
                end
                S_ALO: begin
                    addr_d  = {addr_hi_q, bus.rx_data};
                    state_d = S_LHI;
                end
                S_LHI: begin
                    len_hi_d = bus.rx_data;
                    state_d  = S_LLO;
                end
                S_LLO: begin
                    if (span > SIZE_17) begin
                        state_d = ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = PAYLOAD_END;
                    end else begin
                        cnt_d   = len_full;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    // Register the byte; the write strobe fires on the next cycle.
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = bus.rx_data;
                    addr_d  = addr_q + 15'd1;
                    cnt_d   = cnt_q - 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.rx_data;
`endif
                    if (cnt_q == 16'd1) begin
                        state_d = PAYLOAD_END;
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                CHK: begin
                    state_d = (bus.rx_data == chk_q) ? DONE : ERROR;
                end
`endif
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Release the CPU one cycle after DONE is entered, i.e. after the final
    // write strobe has been presented to the RAM.
    always_comb begin
        rel_d = rel_q | (state_q == DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: registers are updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_hi_q <= 7'd0;
            len_hi_q  <= 8'd0;
            addr_q    <= 15'd0;
            cnt_q     <= 16'd0;
            we_q      <= 1'b0;
            waddr_q   <= 15'd0;
            wdata_q   <= 8'd0;
            rel_q     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            len_hi_q  <= len_hi_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            rel_q     <= rel_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    // Output decode: write port straight from flops, status from the state.
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = waddr_q;
    assign bus.mem_data = wdata_q;
    assign cpu_reset_n  = rel_q;
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign busy         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the boot ROM image. Receives a framed byte stream over a valid/ready byte interface, e.g. from a UART receiver.
- Drives a byte-wide write port into the RAM that backs the 8 KiB ROM window read by the 6502.
- Holds the CPU in reset until a complete, in-range image has been written. On completion it releases the CPU so it fetches the reset vector from the loaded image.

Parameters:
- SIZE, 8192, number of bytes in the target memory; valid addresses are 0..SIZE-1.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a clk edge.
- mem_addr  output  15  write address to image RAM.
- mem_data  output  8  write data to image RAM.
- mem_we  output  1  one-cycle write strobe.
- cpu_reset_n  output  1  active-low CPU reset; low until load completes.
- busy  output  1  high from sync byte accepted until DONE or ERROR.
- done  output  1  load completed successfully (sticky).
- error  output  1  frame rejected (sticky until the next sync byte).

Behaviour:
- Reset values (asynchronous, while reset_n low):
  - state = IDLE; rx_ready = 1.
  - mem_we = 0, mem_addr = 0, mem_data = 0.
  - cpu_reset_n = 0, busy = 0, done = 0, error = 0.
  - Internal address, remaining count and checksum = 0.
- Frame format: SYNC_BYTE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes, then (with the optional feature) CHK.
  - Address and length are big-endian.
  - Only bits [14:0] of the address are used; address bit 15 is ignored.
- State transitions (each advances only on an accepted byte):
  - IDLE: non-sync bytes are discarded; SYNC_BYTE -> S_AHI, and busy goes high.
  - S_AHI -> S_ALO -> S_LHI -> S_LLO.
  - On S_LLO accept, evaluate range: if start + LEN > SIZE (17-bit compare) -> ERROR.
  - Otherwise, LEN == 0 -> CHK when the feature is compiled in, else DONE.
  - Otherwise -> DATA.
- DATA:
  - Each accepted byte is registered and produces mem_we = 1 on the following cycle, with mem_addr = current address and mem_data = byte.
  - After each write the address increments and the remaining count decrements.
  - The byte that takes the count to 0 moves the FSM to CHK or DONE. Its write still issues on the next cycle.
  - Back-to-back bytes every cycle are supported, giving one write per cycle with 1-cycle latency.
- rx_ready:
  - 1 in IDLE, header states, DATA, CHK and ERROR.
  - 0 in DONE.
  - Does not depend on rx_valid in the same cycle.
- DONE (terminal until reset):
  - done = 1, busy = 0.
  - cpu_reset_n goes high on the cycle after the final mem_we, so the last write lands before the CPU runs.
  - All further input is refused.
- ERROR:
  - error = 1, busy = 0, cpu_reset_n remains 0.
  - Bytes are discarded until SYNC_BYTE, which clears error and restarts at S_AHI.
  - Writes already performed are not undone.
- Header bytes equal to SYNC_BYTE inside a frame are data, not a restart.
- An asynchronous reset mid-frame aborts immediately: no further mem_we, cpu_reset_n = 0, FSM returns to IDLE.
- mem_we never asserts outside the cycle following a DATA-state acceptance.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A running XOR of all payload bytes is kept; it resets to 0 on sync.
  - After the payload, the FSM enters CHK and accepts one byte.
  - If that byte equals the running XOR -> DONE; otherwise -> ERROR.
  - cpu_reset_n releases only after a matching CHK byte.
- Without the macro: no CHK state and no checksum register; the frame ends after the last payload byte.

Test Plan:
- Basic load: A5 00 10 00 03 11 22 33 (+CHK 00 if enabled) -> mem_we pulses at 0x0010=11, 0x0011=22, 0x0012=33; done=1; cpu_reset_n rises 1 cycle after the last write.
- Reset vector load: A5 1F FC 00 02 00 80 (+CHK 80) -> writes 0x1FFC=00, 0x1FFD=80; done=1.
- Out of range: A5 1F FF 00 02 -> error=1 after LEN_LO; no mem_we; cpu_reset_n=0. A new A5 00 00 00 01 7E (+7E) -> error clears, done=1.
- Leading garbage / zero length: 00 FF A5 00 00 00 00 (+00) -> garbage ignored, no writes, done=1. Then a further rx_valid sees rx_ready=0.
- Bad checksum (feature on): A5 00 00 00 02 01 02 CHK=00 -> 2 writes occur, error=1, cpu_reset_n stays 0. Feature off: same bytes minus CHK -> done=1.
- Reset mid-frame: assert reset_n=0 after 1 of 3 payload bytes -> outputs return to reset values at once; the remaining bytes sent after reset are ignored until A5.
